// File: rtl/tivi_pkg.sv
// Shared definitions for the screen-RAM side of the video subsystem.
// Holds the RAM address width, blit opcodes and the blit engine state encoding.
package tivi_pkg;

  localparam int SCREEN_ADDR_W = 13;

  localparam logic BLIT_FILL = 1'b0;
  localparam logic BLIT_COPY = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_RD,
    ST_WR,
    ST_FIN
  } blit_state_e;

endpackage

// File: rtl/blit_engine.sv
// Screen-RAM fill/copy engine. CPU writes always own the RAM write port;
// engine writes are deferred around them, and COPY reads only happen in vblank.
module blit_engine
  import tivi_pkg::*;
#(
  parameter int ADDR_W = SCREEN_ADDR_W
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [ADDR_W-1:0] cmd_src,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic [7:0]        cmd_value,
  input  logic              cpu_wen,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_data,
  input  logic              vblank,
  output logic              rd_req,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [7:0]        ram_rdata,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [7:0]        ram_wdata,
  output logic              busy,
  output logic              done
);

  blit_state_e       state_q, state_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [7:0]        value_q, value_d;
  logic [7:0]        data_q, data_d;
  logic              first_q, first_d;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q <= ST_IDLE;
      dst_q   <= '0;
      src_q   <= '0;
      cnt_q   <= '0;
      value_q <= '0;
      data_q  <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dst_q   <= dst_d;
      src_q   <= src_d;
      cnt_q   <= cnt_d;
      value_q <= value_d;
      data_q  <= data_d;
      first_q <= first_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dst_d   = dst_q;
    src_d   = src_q;
    cnt_d   = cnt_q;
    value_d = value_q;
    data_d  = data_q;
    first_d = first_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          dst_d   = cmd_dst;
          src_d   = cmd_src;
          cnt_d   = cmd_len;
          value_d = cmd_value;
          if (cmd_len == '0)           state_d = ST_FIN;
          else if (cmd_op == BLIT_COPY) state_d = ST_RD;
          else                          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        if (!cpu_wen) begin
          dst_d = dst_q + ADDR_W'(1);
          cnt_d = cnt_q - ADDR_W'(1);
          if (cnt_q == ADDR_W'(1)) state_d = ST_FIN;
        end
      end
      ST_RD: begin
        if (vblank) begin
          state_d = ST_WR;
          first_d = 1'b1;
        end
      end
      ST_WR: begin
        // Read data is only valid on the first WR cycle; hold it across CPU stalls.
        if (first_q) begin
          data_d  = ram_rdata;
          first_d = 1'b0;
        end
        if (!cpu_wen) begin
          src_d   = src_q + ADDR_W'(1);
          dst_d   = dst_q + ADDR_W'(1);
          cnt_d   = cnt_q - ADDR_W'(1);
          state_d = (cnt_q == ADDR_W'(1)) ? ST_FIN : ST_RD;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == ST_IDLE);
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_FIN);
    rd_req    = (state_q == ST_RD) && vblank;
    ram_raddr = rd_req ? src_q : '0;
    ram_wen   = 1'b0;
    ram_waddr = '0;
    ram_wdata = '0;
    if (cpu_wen) begin
      ram_wen   = 1'b1;
      ram_waddr = cpu_addr;
      ram_wdata = cpu_data;
    end else if (state_q == ST_FILL) begin
      ram_wen   = 1'b1;
      ram_waddr = dst_q;
      ram_wdata = value_q;
    end else if (state_q == ST_WR) begin
      ram_wen   = 1'b1;
      ram_waddr = dst_q;
      ram_wdata = first_q ? ram_rdata : data_q;
    end
  end

endmodule
